// File: rtl/encoder_output_fifo.sv
// Bit-serializing FIFO: accepts 2-bit encoder symbol pairs and emits them one bit per read.
// Define ENCODER_FIFO_ERROR_FLAG_EN to enable the sticky overflow/underflow error flag.
module encoder_output_fifo #(
   parameter int AD  = 14,
   parameter int MEM = 16384
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [1:0]    data_in,
   input  logic          re,
   output logic          data_out,
   output logic          valid_out,
   output logic          full,
   output logic          empty,
   output logic [AD:0]   count,
   output logic          error
);

   localparam logic [AD:0] FULL_LIMIT = (AD+1)'(MEM - 2);

   logic          r_ram [MEM];
   logic [AD-1:0] r_rptr;
   logic [AD-1:0] r_wptr;
   logic [AD:0]   r_count;
   logic          r_dataOut;
   logic          r_validOut;
   logic          w_wrAccept;
   logic          w_rdAccept;
   logic [AD:0]   w_countNext;

   // Flags come from the registered count, so a bit written this cycle is never readable yet
   assign full       = r_count > FULL_LIMIT;
   assign empty      = r_count == '0;
   assign w_wrAccept = we & ~full;
   assign w_rdAccept = re & ~empty;
   assign count      = r_count;
   assign data_out   = r_dataOut;
   assign valid_out  = r_validOut;

   always_comb begin
      w_countNext = r_count + (w_wrAccept ? (AD+1)'(2) : '0) - (w_rdAccept ? (AD+1)'(1) : '0);
   end

   // Storage is never cleared; reset only makes old contents unreachable
   always_ff @(posedge clk) begin
      if (!reset && w_wrAccept) begin
         r_ram[r_wptr]          <= data_in[1];
         r_ram[r_wptr + AD'(1)] <= data_in[0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rptr     <= '0;
         r_wptr     <= '0;
         r_count    <= '0;
         r_dataOut  <= 1'b0;
         r_validOut <= 1'b0;
      end else begin
         r_count    <= w_countNext;
         r_validOut <= w_rdAccept;
         if (w_wrAccept) begin
            r_wptr <= r_wptr + AD'(2);
         end
         if (w_rdAccept) begin
            r_dataOut <= r_ram[r_rptr];
            r_rptr    <= r_rptr + AD'(1);
         end
      end
   end

`ifdef ENCODER_FIFO_ERROR_FLAG_EN
   logic r_error;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_error <= 1'b0;
      end else if ((we & full) | (re & empty)) begin
         r_error <= 1'b1;
      end
   end

   assign error = r_error;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_output_fifo.sv
// Directed bench for encoder_output_fifo (AD=4, MEM=16): vector table plus hand-written corner sequences.
// Expected error values follow ENCODER_FIFO_ERROR_FLAG_EN when it is defined for the build.
module tb_encoder_output_fifo;

`ifdef ENCODER_FIFO_ERROR_FLAG_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       we;
   logic [1:0] data_in;
   logic       re;
   logic       data_out;
   logic       valid_out;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       error;

   int testsRun;
   int failCount;

   bit   modelQ[$];
   logic expDout;
   logic expValid;
   logic expErr;

   typedef struct {
      logic       rst;
      logic       wr;
      logic [1:0] din;
      logic       rd;
      logic       expDout;
      logic       expValid;
      logic [4:0] expCount;
      logic       expFull;
      logic       expEmpty;
      logic       expErrIfEn;
   } vec_t;

   vec_t vecs[11];

   encoder_output_fifo #(.AD(4), .MEM(16)) dut (
      .clk(clk),
      .reset(reset),
      .we(we),
      .data_in(data_in),
      .re(re),
      .data_out(data_out),
      .valid_out(valid_out),
      .full(full),
      .empty(empty),
      .count(count),
      .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle and advance the reference queue using pre-edge occupancy
   task automatic applyStimulus(input logic rst, input logic w, input logic [1:0] d, input logic r);
      bit wrOk;
      bit rdOk;
      int sz;
      reset   = rst;
      we      = w;
      data_in = d;
      re      = r;
      sz      = modelQ.size();
      wrOk    = !rst && w && (sz <= 14);
      rdOk    = !rst && r && (sz > 0);
      @(posedge clk);
      #1;
      if (rst) begin
         modelQ.delete();
         expDout  = 1'b0;
         expValid = 1'b0;
         expErr   = 1'b0;
      end else begin
         if ((w && sz >= 15) || (r && sz == 0)) expErr = ERR_EN;
         expValid = rdOk;
         if (rdOk) expDout = modelQ.pop_front();
         if (wrOk) begin
            modelQ.push_back(d[1]);
            modelQ.push_back(d[0]);
         end
      end
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, ".count"}, 32'(count), 32'(modelQ.size()));
      checkOutput({tag, ".valid"}, 32'(valid_out), 32'(expValid));
      checkOutput({tag, ".dout"}, 32'(data_out), 32'(expDout));
      checkOutput({tag, ".error"}, 32'(error), 32'(expErr));
   endtask

   initial begin
      bit   inStream[$];
      bit   gotQ[$];
      logic [1:0] d;

      testsRun  = 0;
      failCount = 0;
      expDout   = 1'b0;
      expValid  = 1'b0;
      expErr    = 1'b0;
      reset     = 1'b1;
      we        = 1'b0;
      data_in   = 2'b00;
      re        = 1'b0;

      //            rst   wr    din    rd    dout  vld   count  full  empty errIfEn
      vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].din, vecs[i].rd);
         checkOutput($sformatf("vec%0d.dout", i), 32'(data_out), 32'(vecs[i].expDout));
         checkOutput($sformatf("vec%0d.valid", i), 32'(valid_out), 32'(vecs[i].expValid));
         checkOutput($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].expCount));
         checkOutput($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].expFull));
         checkOutput($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].expEmpty));
         checkOutput($sformatf("vec%0d.error", i), 32'(error), 32'(vecs[i].expErrIfEn & ERR_EN));
      end

      // Fill to capacity, then an overflowing write must not overwrite the oldest pair
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 2'(i), 1'b0);
      checkOutput("full.count16", 32'(count), 32'd16);
      checkOutput("full.flag", 32'(full), 32'd1);
      applyStimulus(1'b0, 1'b1, 2'b11, 1'b0);
      checkOutput("full.ignored", 32'(count), 32'd16);
      checkOutput("full.error", 32'(error), 32'(ERR_EN));
      for (int i = 0; i < 16; i++) begin
         d = 2'(i / 2);
         applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
         checkOutput($sformatf("full.read%0d", i), 32'(data_out), 32'((i % 2 == 0) ? d[1] : d[0]));
      end
      checkOutput("full.drained", 32'(empty), 32'd1);

      // Simultaneous access at count 5, then at count 15 where only the read is accepted
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 2'b10, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
      checkOutput("simul.count5", 32'(count), 32'd5);
      applyStimulus(1'b0, 1'b1, 2'b01, 1'b1);
      checkOutput("simul.count6", 32'(count), 32'd6);
      checkOutput("simul.pulse", 32'(valid_out), 32'd1);
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
      checkOutput("simul.pulseEnd", 32'(valid_out), 32'd0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 2'b11, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
      checkOutput("simul.count15", 32'(count), 32'd15);
      checkOutput("simul.full15", 32'(full), 32'd1);
      applyStimulus(1'b0, 1'b1, 2'b00, 1'b1);
      checkOutput("simul.count14", 32'(count), 32'd14);
      checkModel("simul");

      // Steady-state streaming across several pointer wraps
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 20; i++) begin
         d = 2'((i * 7 + 1) % 4);
         inStream.push_back(d[1]);
         inStream.push_back(d[0]);
         applyStimulus(1'b0, 1'b1, d, 1'b1);
         if (valid_out) gotQ.push_back(data_out);
         applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
         if (valid_out) gotQ.push_back(data_out);
      end
      for (int i = 0; i < 8 && gotQ.size() < 40; i++) begin
         applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
         if (valid_out) gotQ.push_back(data_out);
      end
      checkOutput("wrap.length", 32'(gotQ.size()), 32'd40);
      for (int i = 0; i < 40 && i < gotQ.size(); i++) begin
         checkOutput($sformatf("wrap.bit%0d", i), 32'(gotQ[i]), 32'(inStream[i]));
      end
      checkModel("wrap");

      // Reset in the middle of traffic overrides concurrent we/re
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 2'b11, 1'b0);
      checkOutput("rst.count6", 32'(count), 32'd6);
      applyStimulus(1'b1, 1'b1, 2'b11, 1'b1);
      checkOutput("rst.count", 32'(count), 32'd0);
      checkOutput("rst.valid", 32'(valid_out), 32'd0);
      checkOutput("rst.empty", 32'(empty), 32'd1);
      checkOutput("rst.error", 32'(error), 32'd0);
      applyStimulus(1'b0, 1'b1, 2'b10, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
      checkOutput("rst.fresh0", 32'(data_out), 32'd1);
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
      checkOutput("rst.fresh1", 32'(data_out), 32'd0);
      checkModel("rst");

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
